// File: rtl/textlcd_pkg.sv
// Shared constants, opcode decode and address-step helpers for the text-LCD responder.
package textlcd_pkg;

  // Address map and character constants
  localparam logic [6:0] LINE1_BASE    = 7'h00;
  localparam logic [6:0] LINE2_BASE    = 7'h40;
  localparam logic [6:0] LINE1_LAST    = 7'h27;
  localparam logic [6:0] LINE2_LAST    = 7'h67;
  localparam logic [6:0] ONE_LINE_LAST = 7'h4F;
  localparam int         VISIBLE_COLS  = 16;
  localparam int         NUM_CELLS     = 2 * VISIBLE_COLS;
  localparam logic [7:0] CH_BLANK      = 8'h20;
  localparam logic [7:0] CH_ZERO       = 8'h30;

  // Instruction opcode masks and values, listed from highest set bit down
  localparam logic [7:0] OP_DDRAM_MASK = 8'h80, OP_DDRAM_VAL = 8'h80;
  localparam logic [7:0] OP_CGRAM_MASK = 8'hC0, OP_CGRAM_VAL = 8'h40;
  localparam logic [7:0] OP_FUNC_MASK  = 8'hE0, OP_FUNC_VAL  = 8'h20;
  localparam logic [7:0] OP_SHIFT_MASK = 8'hF0, OP_SHIFT_VAL = 8'h10;
  localparam logic [7:0] OP_DISP_MASK  = 8'hF8, OP_DISP_VAL  = 8'h08;
  localparam logic [7:0] OP_ENTRY_MASK = 8'hFC, OP_ENTRY_VAL = 8'h04;
  localparam logic [7:0] OP_HOME_MASK  = 8'hFE, OP_HOME_VAL  = 8'h02;
  localparam logic [7:0] OP_CLEAR_MASK = 8'hFF, OP_CLEAR_VAL = 8'h01;

  typedef enum logic [3:0] {
    I_NOP, I_CLEAR, I_HOME, I_ENTRY, I_DISPLAY, I_SHIFT, I_FUNC, I_CGRAM, I_DDRAM
  } instr_e;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  // Highest set opcode bit selects the instruction class
  function automatic instr_e decode_instr(input logic [7:0] d);
    instr_e r;
    if      ((d & OP_DDRAM_MASK) == OP_DDRAM_VAL) r = I_DDRAM;
    else if ((d & OP_CGRAM_MASK) == OP_CGRAM_VAL) r = I_CGRAM;
    else if ((d & OP_FUNC_MASK)  == OP_FUNC_VAL)  r = I_FUNC;
    else if ((d & OP_SHIFT_MASK) == OP_SHIFT_VAL) r = I_SHIFT;
    else if ((d & OP_DISP_MASK)  == OP_DISP_VAL)  r = I_DISPLAY;
    else if ((d & OP_ENTRY_MASK) == OP_ENTRY_VAL) r = I_ENTRY;
    else if ((d & OP_HOME_MASK)  == OP_HOME_VAL)  r = I_HOME;
    else if ((d & OP_CLEAR_MASK) == OP_CLEAR_VAL) r = I_CLEAR;
    else                                          r = I_NOP;
    return r;
  endfunction

  // Step the DDRAM address counter one position, applying the line wrap points;
  // addresses outside the wrap points simply count by one.
  function automatic logic [6:0] next_addr(input logic [6:0] a, input logic inc,
                                           input logic two_line);
    logic [6:0] r;
    if (two_line) begin
      if (inc) r = (a == LINE1_LAST) ? LINE2_BASE : (a == LINE2_LAST) ? LINE1_BASE : a + 7'd1;
      else     r = (a == LINE1_BASE) ? LINE2_LAST : (a == LINE2_BASE) ? LINE1_LAST : a - 7'd1;
    end else begin
      if (inc) r = (a == ONE_LINE_LAST) ? LINE1_BASE : a + 7'd1;
      else     r = (a == LINE1_BASE) ? ONE_LINE_LAST : a - 7'd1;
    end
    return r;
  endfunction

  // True when the address maps onto one of the 32 shadowed cells
  function automatic logic is_visible(input logic [6:0] a);
    return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
  endfunction

endpackage

// File: rtl/lcd_bus_sampler.sv
// Synchronizes the LCD bus, captures RS/RW/DATA while E is high and flags
// a commit on the falling edge of synchronized E.
module lcd_bus_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  output logic       commit,
  output logic       rs,
  output logic       rw,
  output logic [7:0] data
);

  // {e, rs, rw, data} per synchronizer stage
  logic [10:0] sync_q [SYNC_STAGES];
  logic        e_prev_q;
  logic        rs_q, rw_q;
  logic [7:0]  data_q;
  logic [10:0] bus_s;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      // One synchronizer stage; stage 0 samples the raw pins
      always_ff @(posedge clk) begin
        if (reset) sync_q[gi] <= '0;
        else if (gi == 0) sync_q[gi] <= {lcd_e, lcd_rs, lcd_rw, lcd_data};
        else sync_q[gi] <= sync_q[(gi == 0) ? 0 : gi - 1];
      end
    end
  endgenerate

  assign bus_s = sync_q[SYNC_STAGES-1];

  // Track E for edge detect and keep the last fields seen while E was high
  always_ff @(posedge clk) begin
    if (reset) begin
      e_prev_q <= 1'b0;
      rs_q     <= 1'b0;
      rw_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      e_prev_q <= bus_s[10];
      if (bus_s[10]) begin
        rs_q   <= bus_s[9];
        rw_q   <= bus_s[8];
        data_q <= bus_s[7:0];
      end
    end
  end

  assign commit = e_prev_q & ~bus_s[10];
  assign rs     = rs_q;
  assign rw     = rw_q;
  assign data   = data_q;

endmodule

// File: rtl/textlcd_rx.sv
// Character-LCD bus responder: decodes E-strobed transfers and keeps a
// 2x16 shadow of the visible DDRAM.
module textlcd_rx
  import textlcd_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int CLEAR_CYCLES = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         lcd_e,
  input  logic         lcd_rs,
  input  logic         lcd_rw,
  input  logic [7:0]   lcd_data,
  output logic [127:0] line1_data,
  output logic [127:0] line2_data,
  output logic [6:0]   cur_addr,
  output logic         disp_on,
  output logic         two_line,
  output logic         busy,
  output logic         cmd_strobe,
  output logic         data_strobe,
  output logic         protocol_err
);

  localparam int CNT_W = $clog2(CLEAR_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLEAR_CYCLES - 1);

  logic       commit, s_rs, s_rw;
  logic [7:0] s_data;

  lcd_bus_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .clk      (clk),
    .reset    (reset),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_data (lcd_data),
    .commit   (commit),
    .rs       (s_rs),
    .rw       (s_rw),
    .data     (s_data)
  );

  // Cells 0-15 are line 1 columns, 16-31 are line 2 columns
  logic [7:0]       cells_q [NUM_CELLS];
  state_e           state_q;
  logic [CNT_W-1:0] clr_cnt_q;
  logic [6:0]       addr_q;
  logic             inc_q, disp_on_q, two_line_q, busy_q;
  logic             cmd_stb_q, data_stb_q, err_q;

  // Controller FSM: clear sequencing, instruction decode and data writes
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CELLS; i++) cells_q[i] <= CH_BLANK;
      state_q    <= ST_IDLE;
      clr_cnt_q  <= '0;
      addr_q     <= LINE1_BASE;
      inc_q      <= 1'b1;
      disp_on_q  <= 1'b0;
      two_line_q <= 1'b0;
      busy_q     <= 1'b0;
      cmd_stb_q  <= 1'b0;
      data_stb_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cmd_stb_q  <= 1'b0;
      data_stb_q <= 1'b0;
      err_q      <= 1'b0;

      if (state_q == ST_CLEAR) begin
        if (int'(clr_cnt_q) < NUM_CELLS) cells_q[clr_cnt_q[4:0]] <= CH_BLANK;
        clr_cnt_q <= clr_cnt_q + 1'b1;
        if (clr_cnt_q == CNT_LAST) begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      end

      // Reads are ignored; writes during CLEAR are dropped except on its final cycle
      if (commit && !s_rw) begin
        if (state_q == ST_CLEAR && clr_cnt_q != CNT_LAST) begin
          err_q <= 1'b1;
        end else if (s_rs) begin
          data_stb_q <= 1'b1;
          if (is_visible(addr_q)) cells_q[{addr_q[6], addr_q[3:0]}] <= s_data;
          addr_q <= next_addr(addr_q, inc_q, two_line_q);
        end else begin
          cmd_stb_q <= 1'b1;
          case (decode_instr(s_data))
            I_DDRAM:   addr_q <= s_data[6:0];
            I_FUNC:    two_line_q <= s_data[3];
            I_SHIFT:   if (!s_data[3]) addr_q <= next_addr(addr_q, s_data[2], two_line_q);
            I_DISPLAY: disp_on_q <= s_data[2];
            I_ENTRY:   inc_q <= s_data[1];
            I_HOME:    addr_q <= LINE1_BASE;
            I_CLEAR: begin
              state_q   <= ST_CLEAR;
              busy_q    <= 1'b1;
              clr_cnt_q <= '0;
              addr_q    <= LINE1_BASE;
              inc_q     <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Pack the shadow cells so column 0 lands in the top byte of each line
  genvar gi;
  generate
    for (gi = 0; gi < VISIBLE_COLS; gi++) begin : g_pack
      assign line1_data[127-8*gi -: 8] = cells_q[gi];
      assign line2_data[127-8*gi -: 8] = cells_q[VISIBLE_COLS + gi];
    end
  endgenerate

  assign cur_addr     = addr_q;
  assign disp_on      = disp_on_q;
  assign two_line     = two_line_q;
  assign busy         = busy_q;
  assign cmd_strobe   = cmd_stb_q;
  assign data_strobe  = data_stb_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_textlcd_rx.sv
// Directed bench for textlcd_rx with a strobe scoreboard.
module tb_textlcd_rx;

  localparam int S = 2;
  localparam int KIND_CMD = 0, KIND_DATA = 1, KIND_ERR = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0]   lcd_data = 8'h00;
  logic [127:0] line1_data, line2_data;
  logic [6:0]   cur_addr;
  logic         disp_on, two_line, busy, cmd_strobe, data_strobe, protocol_err;

  textlcd_rx #(.SYNC_STAGES(S), .CLEAR_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data), .line1_data(line1_data), .line2_data(line2_data),
    .cur_addr(cur_addr), .disp_on(disp_on), .two_line(two_line), .busy(busy),
    .cmd_strobe(cmd_strobe), .data_strobe(data_strobe), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; longint cyc; } ev_t;
  ev_t    sb[$];
  longint cyc_cnt = 0;
  int     checks = 0, errors = 0;
  int     n_cmd = 0, n_data = 0, n_err = 0, busy_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input string s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = (i < s.len()) ? 8'(s[i]) : 8'h20;
    return r;
  endfunction

  // Strobe monitor: every pulse must match the next scoreboard entry
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_cnt++;
      if (cmd_strobe || data_strobe || protocol_err) begin
        ev_t e;
        int  k;
        k = cmd_strobe ? KIND_CMD : data_strobe ? KIND_DATA : KIND_ERR;
        if (cmd_strobe) n_cmd++;
        if (data_strobe) n_data++;
        if (protocol_err) n_err++;
        check("strobe_overlap", 128'(int'(cmd_strobe) + int'(data_strobe) + int'(protocol_err)), 128'd1);
        if (sb.size() == 0) begin
          check("strobe_unexpected", 128'(k), 128'hFF);
        end else begin
          e = sb.pop_front();
          check("strobe_kind", 128'(k), 128'(e.kind));
          check("strobe_cycle", 128'(cyc_cnt), 128'(e.cyc));
        end
      end
    end
  end

  // One bus transfer; E high 3 clk, low 3 clk; pushes the expected strobe
  task automatic xfer(input bit rs, input bit rw, input logic [7:0] d, input bit exp_err = 1'b0);
    ev_t e;
    @(posedge clk); #1;
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    repeat (3) @(posedge clk);
    #1 lcd_e = 1'b0;
    if (!rw) begin
      e.kind = exp_err ? KIND_ERR : (rs ? KIND_DATA : KIND_CMD);
      e.cyc  = cyc_cnt + S + 1;
      sb.push_back(e);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) xfer(1'b1, 1'b0, 8'(s[i]));
  endtask

  task automatic wait_busy(input logic lvl);
    int n = 0;
    while (busy !== lvl && n < 100) begin @(negedge clk); n++; end
    check("busy_wait", 128'(busy), 128'(lvl));
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
    check("sb_drained", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_line1", line1_data, line_of(""));
    check("rst_line2", line2_data, line_of(""));
    check("rst_addr", 128'(cur_addr), 128'h00);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_disp_two", 128'({disp_on, two_line}), 128'd0);

    // Driver init then line 1 text
    xfer(0, 0, 8'h38); xfer(0, 0, 8'h0C); xfer(0, 0, 8'h06); xfer(0, 0, 8'h80);
    send_str("CLOCK MODE");
    drain();
    check("init_two_line", 128'(two_line), 128'd1);
    check("init_disp_on", 128'(disp_on), 128'd1);
    check("init_line1", line1_data, line_of("CLOCK MODE"));
    check("init_addr", 128'(cur_addr), 128'h0A);
    check("init_ncmd", 128'(n_cmd), 128'd4);
    check("init_ndata", 128'(n_data), 128'd10);

    // Line 2 starting at column 8
    xfer(0, 0, 8'hC8);
    send_str("12:34:56");
    drain();
    check("l2_line2", line2_data, line_of("        12:34:56"));
    check("l2_addr", 128'(cur_addr), 128'h50);
    check("l2_line1", line1_data, line_of("CLOCK MODE"));

    // Increment wrap 0x27 -> 0x40
    xfer(0, 0, 8'hA7);
    send_str("XY");
    drain();
    check("incw_line2", line2_data, line_of("Y       12:34:56"));
    check("incw_addr", 128'(cur_addr), 128'h41);

    // Decrement wrap 0x40 -> 0x27
    xfer(0, 0, 8'h04); xfer(0, 0, 8'hC0);
    send_str("Z");
    drain();
    check("decw_line2", line2_data, line_of("Z       12:34:56"));
    check("decw_addr", 128'(cur_addr), 128'h27);

    // A read cycle must be ignored even with a Clear opcode on the bus
    xfer(0, 1, 8'h01);
    drain();
    check("read_busy", 128'(busy), 128'd0);
    check("read_addr", 128'(cur_addr), 128'h27);

    // Fill both lines, then Clear with a write arriving mid-clear
    xfer(0, 0, 8'h06); xfer(0, 0, 8'h80);
    send_str("ABCDEFGHIJKLMNOP");
    xfer(0, 0, 8'hC0);
    send_str("abcdefghijklmnop");
    drain();
    check("fill_line1", line1_data, line_of("ABCDEFGHIJKLMNOP"));
    check("fill_line2", line2_data, line_of("abcdefghijklmnop"));
    busy_cnt = 0; n_err = 0;
    xfer(0, 0, 8'h01);
    wait_busy(1'b1);
    repeat (5) @(posedge clk);
    xfer(1, 0, 8'h51, 1'b1);
    wait_busy(1'b0);
    drain();
    check("clr_busy_len", 128'(busy_cnt), 128'd32);
    check("clr_perr", 128'(n_err), 128'd1);
    check("clr_line1", line1_data, line_of(""));
    check("clr_line2", line2_data, line_of(""));
    check("clr_addr", 128'(cur_addr), 128'h00);
    send_str("A");
    drain();
    check("post_clr_line1", line1_data, line_of("A"));
    check("post_clr_addr", 128'(cur_addr), 128'h01);

    // Reset at cycle 10 of a Clear
    xfer(0, 0, 8'h01);
    wait_busy(1'b1);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("rstclr_busy", 128'(busy), 128'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rstclr_line1", line1_data, line_of(""));
    check("rstclr_addr", 128'(cur_addr), 128'h00);
    check("rstclr_two_line", 128'(two_line), 128'd0);

    // Reset between E falling and the commit: transfer is lost
    @(posedge clk); #1;
    lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h57; lcd_e = 1'b1;
    repeat (3) @(posedge clk);
    #1 lcd_e = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    drain();
    check("rststb_line1", line1_data, line_of(""));
    check("rststb_addr", 128'(cur_addr), 128'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/textlcd_rx.md
Name: textlcd_rx

Overview:
- Responder end of the HD44780-style character-LCD bus (E/RS/RW/DATA) that our text-LCD drivers emit.
- Oversamples the bus on a faster system clock and decodes each E-strobed transfer as an instruction or a data write.
- Maintains a 2x16 shadow display buffer, exported in the same packed 128-bit-per-line format the driver side uses.
- Used as a bus monitor/mirror on-chip and as the scoreboard model for LCD driver verification.

Parameters:
- SYNC_STAGES, 2: synchronizer depth on lcd_e, lcd_rs, lcd_rw and lcd_data.
- CLEAR_CYCLES, 32: busy duration of Clear Display, one cell blanked per cycle; must be ≥32.

Ports:
- clk  in  1  system clock; must be ≥4x the lcd_e toggle rate.
- reset  in  1  synchronous, active-high reset.
- lcd_e  in  1  bus enable strobe; the transfer commits on its falling edge.
- lcd_rs  in  1  0 = instruction, 1 = data.
- lcd_rw  in  1  0 = write, 1 = read.
- lcd_data  in  8  bus data.
- line1_data  out  128  visible DDRAM 0x00-0x0F; [127:120] is column 0.
- line2_data  out  128  visible DDRAM 0x40-0x4F; same packing as line1_data.
- cur_addr  out  7  current DDRAM address counter.
- disp_on  out  1  D bit of the last Display On/Off instruction.
- two_line  out  1  N bit of the last Function Set instruction.
- busy  out  1  high during a Clear Display.
- cmd_strobe  out  1  1-cycle pulse for each accepted instruction.
- data_strobe  out  1  1-cycle pulse for each accepted data write.
- protocol_err  out  1  1-cycle pulse when a transfer is dropped.

Behaviour:
- Reset (synchronous): line1_data and line2_data all 0x20; cur_addr 0; inc (I/D) = 1; disp_on 0; two_line 0; busy 0; all pulses 0; FSM in IDLE.
- Sampling:
  - All four bus inputs pass through SYNC_STAGES flops.
  - While synchronized E is high, RS/RW/DATA are captured every cycle.
  - A falling edge of synchronized E commits the last captured values.
  - The transfer acts, and its strobe pulses, SYNC_STAGES+1 clk after lcd_e falls.
- RW=1 transfers: ignored (no busy-flag readback); no strobe, no protocol_err.
- Instruction decode (RS=0), highest set bit wins:
  - 1xxxxxxx: Set DDRAM address; cur_addr = data[6:0].
  - 01xxxxxx: Set CGRAM address; ignored, but cmd_strobe still pulses.
  - 001DNFxx: two_line = N.
  - 0001SRxx: if S=0, cursor move (R=1 increment, R=0 decrement, wrap rules below); display shift (S=1) ignored.
  - 00001DCB: disp_on = D.
  - 000001IS: inc = I; S ignored.
  - 0000001x: Return Home; cur_addr = 0.
  - 00000001: Clear Display; FSM enters CLEAR, cur_addr = 0, inc = 1.
  - 0x00: no-op; cmd_strobe still pulses.
- Data write (RS=1):
  - If cur_addr is 0x00-0x0F or 0x40-0x4F, write data into the matching byte; otherwise discard the byte.
  - In both cases, advance cur_addr per inc.
- Address wrap, two_line=1:
  - Increment: 0x27→0x40, 0x67→0x00.
  - Decrement: 0x00→0x67, 0x40→0x27.
- Address wrap, two_line=0:
  - Increment: 0x4F→0x00.
  - Decrement: 0x00→0x4F.
- Out-of-range addresses set by instruction (e.g. 0x28-0x3F) are kept as given and step by ±1 until they reach a wrap point.
- FSM states: IDLE and CLEAR.
  - CLEAR: busy = 1; blank one cell per cycle, index 0-31 (line1 cols 0-15, then line2 cols 0-15).
  - Stay in CLEAR for CLEAR_CYCLES cycles, then return to IDLE.
  - Any committed RW=0 transfer during CLEAR is dropped and pulses protocol_err.
- Simultaneous events: a commit on the cycle CLEAR exits is processed normally. Strobes never overlap; at most one commit per 2 clk.
- Reset mid-CLEAR or mid-strobe: everything returns to reset values, the pending transfer is lost, and no strobe is issued.

Decomposition:
- Shared package textlcd_pkg:
  - Instruction opcode masks and values.
  - Address constants: LINE1_BASE 0x00, LINE2_BASE 0x40, LINE_LAST 0x27/0x67, VISIBLE_COLS 16.
  - Character constants (blank 0x20, digit zero 0x30).
  - FSM state encoding.
- Sub-module lcd_bus_sampler:
  - Contains the synchronizer, E falling-edge detect and field capture.
  - Outputs commit, rs, rw, data.

Test Plan:
- Reset check: after reset, line1_data = line2_data = all 0x20, cur_addr = 0, busy = 0.
- Driver init then line 1: bytes 0x38, 0x0C, 0x06, 0x80, then ASCII "CLOCK MODE" → two_line = 1, disp_on = 1, line1 cols 0-9 = "CLOCK MODE", cur_addr = 0x0A, 4 cmd_strobe + 10 data_strobe pulses.
- Line 2 at column 8: 0xC8 then "12:34:56" → line2 cols 8-15 = "12:34:56", cur_addr = 0x50, line1 unchanged.
- Increment wrap: 0xA7, 'X', 'Y' → 'X' discarded (0x27 not visible); 'Y' at line2 col 0; cur_addr = 0x41.
- Decrement wrap: 0x04, 0xC0, 'Z' → line2 col 0 = 'Z', cur_addr = 0x27.
- Clear handling: fill both lines, send 0x01, send 'Q' 5 clk after the commit → busy high for 32 cycles, protocol_err pulses once, both lines all 0x20 afterwards. Repeat with reset asserted at cycle 10 of CLEAR → reset values, busy = 0 on the next cycle.
